// File: rtl/lpm_sub_seq_if.sv
// Operand/result handshake bus for lpm_sub_seq.
// Optional add_sub lane is present only when LPM_SUB_SEQ_ADD_EN is defined.
interface lpm_sub_seq_if #(parameter int lpm_width = 32);
  logic                 in_valid;
  logic                 in_ready;
  logic [lpm_width-1:0] dataa;
  logic [lpm_width-1:0] datab;
  logic                 bin;
`ifdef LPM_SUB_SEQ_ADD_EN
  logic                 add_sub;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [lpm_width-1:0] result;
  logic                 bout;
  logic                 overflow;

  // Producer/consumer side (operand registers + result bus)
  modport master (
    output in_valid, dataa, datab, bin,
`ifdef LPM_SUB_SEQ_ADD_EN
    output add_sub,
`endif
    output out_ready,
    input  in_ready, out_valid, result, bout, overflow
  );

  // Sequential subtractor side
  modport slave (
    input  in_valid, dataa, datab, bin,
`ifdef LPM_SUB_SEQ_ADD_EN
    input  add_sub,
`endif
    input  out_ready,
    output in_ready, out_valid, result, bout, overflow
  );
endinterface

// File: rtl/lpm_sub_seq.sv
// Multi-cycle chunked subtractor: result = dataa - datab - bin, chunk_width
// bits per RUN cycle with the borrow rippling through a register.
// Optional macro LPM_SUB_SEQ_ADD_EN adds an add_sub select (1 = add, carry
// reported on bout) with identical latency.
module lpm_sub_seq #(
  parameter int lpm_width   = 32,
  parameter int chunk_width = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  lpm_sub_seq_if.slave bus
);
  localparam int N  = lpm_width / chunk_width;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = chunk_width;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [lpm_width-1:0] a_q, b_q, result_q;
  logic                 brw, bout_q, ovf_q;
  logic [KW-1:0]        k;
  logic                 last;
  logic                 add_q;
  logic [CW-1:0]        a_chk, b_chk;
  logic [CW:0]          chk_full;
  logic                 ovf_nx;

  assign bus.in_ready  = (state == IDLE) & reset_n;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.bout      = bout_q;
  assign bus.overflow  = ovf_q;

  assign last = (k == KW'(N - 1));

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: accept in IDLE, N RUN cycles, hold in DONE until consumed
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last)         state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One chunk of the ripple: top bit of the (CW+1)-bit result is borrow/carry
  always_comb begin
    a_chk = a_q[int'(k)*CW +: CW];
    b_chk = b_q[int'(k)*CW +: CW];
    if (add_q) begin
      chk_full = {1'b0, a_chk} + {1'b0, b_chk} + {{CW{1'b0}}, brw};
      ovf_nx   = (a_q[lpm_width-1] == b_q[lpm_width-1]) &
                 (chk_full[CW-1] != a_q[lpm_width-1]);
    end else begin
      chk_full = {1'b0, a_chk} - {1'b0, b_chk} - {{CW{1'b0}}, brw};
      ovf_nx   = (a_q[lpm_width-1] != b_q[lpm_width-1]) &
                 (chk_full[CW-1] != a_q[lpm_width-1]);
    end
  end

`ifdef LPM_SUB_SEQ_ADD_EN
  // Operation select captured with the operands
  always_ff @(posedge clock) begin
    if (!reset_n)                              add_q <= 1'b0;
    else if (state == IDLE && bus.in_valid)    add_q <= bus.add_sub;
  end
`else
  assign add_q = 1'b0;
`endif

  // Operand latch, chunk walk and result/flag capture
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      brw      <= 1'b0;
      k        <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q <= bus.dataa;
          b_q <= bus.datab;
          brw <= bus.bin;
          k   <= '0;
        end
        RUN: begin
          result_q[int'(k)*CW +: CW] <= chk_full[CW-1:0];
          brw <= chk_full[CW];
          k   <= k + KW'(1);
          if (last) begin
            bout_q <= chk_full[CW];
            ovf_q  <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lpm_sub_seq.sv
// Self-checking bench for lpm_sub_seq (lpm_width=32, chunk_width=8).
// Build with LPM_SUB_SEQ_ADD_EN defined to also exercise the add path.
module tb_lpm_sub_seq;
  localparam int W  = 32;
  localparam int CW = 8;
  localparam int N  = W / CW;

  logic clock = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  lpm_sub_seq_if #(.lpm_width(W)) bus ();

  lpm_sub_seq #(.lpm_width(W), .chunk_width(CW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic on wide integers
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bi, input logic ad,
                                output logic [W-1:0] r, output logic bo, output logic ov);
    longint s;
    if (ad) begin
      s  = longint'(a) + longint'(b) + longint'(bi);
      r  = s[W-1:0];
      bo = s[W];
      ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r  = a - b - W'(bi);
      bo = longint'(a) < (longint'(b) + longint'(bi));
      ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
  endfunction

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input logic ad);
    bus.dataa = a; bus.datab = b; bus.bin = bi;
`ifdef LPM_SUB_SEQ_ADD_EN
    bus.add_sub = ad;
`endif
  endtask

  // Wait for in_ready, hand in operands, then check latency, hold under stall and result
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input logic ad, input int stall);
    logic [W-1:0] er; logic eb, eo;
    logic [W-1:0] r0; logic b0, o0;
    int cnt;
    model(a, b, bi, ad, er, eb, eo);
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin @(negedge clock); cnt++; end
    chk("in_ready_wait", W'(bus.in_ready), W'(1));
    drive_op(a, b, bi, ad);
    bus.in_valid = 1'b1;
    @(negedge clock);                       // accept edge T has passed
    cnt = 0;
    while (!bus.out_valid && cnt < 3*N + 4) begin
      // inputs are not sampled after the latch, out_ready has no effect yet
      drive_op($urandom, $urandom, 1'($urandom), 1'($urandom));
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      chk("in_ready_run", W'(bus.in_ready), W'(0));
      @(negedge clock);
      cnt++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    // out_valid becomes visible after edge T+N
    chk("latency", W'(cnt), W'(N));
    chk("result", bus.result, er);
    chk("bout", W'(bus.bout), W'(eb));
    chk("overflow", W'(bus.overflow), W'(eo));
    r0 = bus.result; b0 = bus.bout; o0 = bus.overflow;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'($urandom);
      drive_op($urandom, $urandom, 1'($urandom), 1'($urandom));
      @(negedge clock);
      chk("stall_valid", W'(bus.out_valid), W'(1));
      chk("stall_ready", W'(bus.in_ready), W'(0));
      chk("stall_result", bus.result, r0);
      chk("stall_flags", W'({bus.bout, bus.overflow}), W'({b0, o0}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("consumed_valid", W'(bus.out_valid), W'(0));
    chk("consumed_in_ready", W'(bus.in_ready), W'(1));
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive_op('0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk("rst_in_ready", W'(bus.in_ready), W'(0));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_result", bus.result, W'(0));
    chk("rst_flags", W'({bus.bout, bus.overflow}), W'(0));
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", W'(bus.in_ready), W'(1));

    // Directed subtract cases
    run_op(32'd5, 32'd3, 1'b0, 1'b0, 0);
    run_op(32'd0, 32'd1, 1'b0, 1'b0, 0);
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b0, 0);
    run_op(32'h0000_0100, 32'd1, 1'b1, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 0);
    // Backpressure: ten cycles of out_ready low, stray in_valid
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 10);

    // Reset during chunk 2 abandons the operation
    drive_op(32'd9, 32'd4, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrun_rst_in_ready", W'(bus.in_ready), W'(0));
    chk("midrun_rst_valid", W'(bus.out_valid), W'(0));
    chk("midrun_rst_result", bus.result, W'(0));
    chk("midrun_rst_flags", W'({bus.bout, bus.overflow}), W'(0));
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrun_rel_in_ready", W'(bus.in_ready), W'(1));
    seen = 1'b0;
    repeat (8) begin
      bus.out_ready = 1'($urandom);
      @(negedge clock);
      if (bus.out_valid) seen = 1'b1;
    end
    bus.out_ready = 1'b0;
    chk("midrun_no_valid", W'(seen), W'(0));

`ifdef LPM_SUB_SEQ_ADD_EN
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 3);
`endif

    // Randomized operations with occasional stalls and edge operands
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = '0;
        1: b = '1;
        2: b = a;
        default: ;
      endcase
`ifdef LPM_SUB_SEQ_ADD_EN
      run_op(a, b, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
`else
      run_op(a, b, 1'($urandom), 1'b0, $urandom_range(0, 3));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
